// File: rtl/sound_pkg.sv
// Shared definitions for the game sound sequencer: sequence codes (also used by
// the tone generator), FSM state encoding and event priority order.
package sound_pkg;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_SCORE = 2'b01;
  localparam logic [1:0] SEL_HIGH  = 2'b10;
  localparam logic [1:0] SEL_END   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Lowest priority in the least significant slot; slot index is the rank.
  localparam logic [7:0] PRIO_ORDER = {SEL_END, SEL_HIGH, SEL_START, SEL_SCORE};

  function automatic logic [1:0] prio_rank(input logic [1:0] code);
    logic [1:0] rank;
    rank = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (PRIO_ORDER[2*i +: 2] == code) rank = 2'(i);
    end
    return rank;
  endfunction

endpackage

// File: rtl/sound_priority_encoder.sv
// Fixed-priority pick of the winning pending event; pending bits are indexed
// by sequence code.
module sound_priority_encoder
  import sound_pkg::*;
(
  input  logic [3:0] pending,
  output logic       valid,
  output logic [1:0] sel
);

  always_comb begin
    valid = 1'b0;
    sel   = SEL_START;
    // Walk from lowest to highest rank so the highest pending bit wins.
    for (int i = 0; i < 4; i++) begin
      if (pending[PRIO_ORDER[2*i +: 2]]) begin
        valid = 1'b1;
        sel   = PRIO_ORDER[2*i +: 2];
      end
    end
  end

endmodule

// File: rtl/sound_event_sequencer.sv
// Latches game events and paces tone-generator sequences with a silent gap.
// Optional feature macro: SOUND_PREEMPT_EN (higher-priority event restarts playback).
module sound_event_sequencer
  import sound_pkg::*;
#(
  parameter int NOTE_CYCLES   = 25_000_000,
  parameter int NOTES_PER_SEQ = 8,
  parameter int GAP_CYCLES    = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       evt_start,
  input  logic       evt_score,
  input  logic       evt_high,
  input  logic       evt_end,
  input  logic       mute,
  output logic [1:0] sel,
  output logic [2:0] note_idx,
  output logic       note_strobe,
  output logic       play,
  output logic       busy,
  output logic       seq_done
);

  localparam int         NW        = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam int         GW        = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [2:0] LAST_NOTE = 3'(NOTES_PER_SEQ - 1);

  state_t        state_q, state_d;
  logic [3:0]    pending_q, pending_d, evt_vec, clr_vec;
  logic [1:0]    sel_q, sel_d;
  logic [2:0]    note_idx_q, note_idx_d;
  logic [NW-1:0] note_cnt_q, note_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          strobe_q, strobe_d;
  logic          done_q, done_d;
  logic          win_valid;
  logic [1:0]    win_sel;
  logic          note_wrap, last_wrap, gap_end, preempt;

  assign evt_vec = {evt_end, evt_high, evt_score, evt_start};

  sound_priority_encoder u_prio (
    .pending(pending_q),
    .valid  (win_valid),
    .sel    (win_sel)
  );

  assign note_wrap = 32'(note_cnt_q) >= 32'(NOTE_CYCLES - 1);
  assign last_wrap = note_wrap && (note_idx_q >= LAST_NOTE);
  assign gap_end   = 32'(gap_cnt_q) >= 32'(GAP_CYCLES - 1);

`ifdef SOUND_PREEMPT_EN
  assign preempt = (state_q == PLAY) && win_valid && (prio_rank(win_sel) > prio_rank(sel_q));
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      sel_q      <= '0;
      note_idx_q <= '0;
      note_cnt_q <= '0;
      gap_cnt_q  <= '0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      note_idx_q <= note_idx_d;
      note_cnt_q <= note_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_valid) state_d = PLAY;
      PLAY:    if (!preempt && last_wrap) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_vec    = '0;
    sel_d      = sel_q;
    note_idx_d = note_idx_q;
    note_cnt_d = note_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    if ((state_q == IDLE && win_valid) || preempt) begin
      // Start (or restart) playback of the winning event; its pending bit is consumed.
      clr_vec[win_sel] = 1'b1;
      sel_d            = win_sel;
      note_idx_d       = '0;
      note_cnt_d       = '0;
    end else if (state_q == PLAY) begin
      if (note_wrap) begin
        note_cnt_d = '0;
        if (last_wrap) begin
          done_d    = 1'b1;
          gap_cnt_d = '0;
        end else begin
          note_idx_d = note_idx_q + 3'd1;
          strobe_d   = 1'b1;
        end
      end else begin
        note_cnt_d = note_cnt_q + 1'b1;
      end
    end else if (state_q == GAP && !gap_end) begin
      gap_cnt_d = gap_cnt_q + 1'b1;
    end
    pending_d = (pending_q & ~clr_vec) | evt_vec;
  end

  always_comb begin
    sel         = sel_q;
    note_idx    = note_idx_q;
    note_strobe = strobe_q;
    seq_done    = done_q;
    play        = (state_q == PLAY) && !mute;
    busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Scoreboard bench for sound_event_sequencer with short note/gap timing;
// honours SOUND_PREEMPT_EN for the preemption scenario.
`timescale 1ns/1ps
module tb_sound_event_sequencer;
  import sound_pkg::*;

  localparam int NC      = 4;
  localparam int NS      = 8;
  localparam int GC      = 3;
  localparam int SEQ_LEN = NC * NS;

  localparam int K_START  = 0;
  localparam int K_STROBE = 1;
  localparam int K_DONE   = 2;
  localparam int K_IDLE   = 3;

  typedef struct {
    int         kind;
    int         cyc;
    logic [1:0] sel;
    int         idx;
    int         pc;
  } txn_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       evt_start = 1'b0, evt_score = 1'b0, evt_high = 1'b0, evt_end = 1'b0;
  logic       mute = 1'b0;
  logic [1:0] sel;
  logic [2:0] note_idx;
  logic       note_strobe, play, busy, seq_done;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  txn_t exp_q[$];

  sound_event_sequencer #(
    .NOTE_CYCLES  (NC),
    .NOTES_PER_SEQ(NS),
    .GAP_CYCLES   (GC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .evt_start  (evt_start),
    .evt_score  (evt_score),
    .evt_high   (evt_high),
    .evt_end    (evt_end),
    .mute       (mute),
    .sel        (sel),
    .note_idx   (note_idx),
    .note_strobe(note_strobe),
    .play       (play),
    .busy       (busy),
    .seq_done   (seq_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_START:  return "start";
      K_STROBE: return "strobe";
      K_DONE:   return "done";
      default:  return "idle";
    endcase
  endfunction

  task automatic push(int kind, int c, logic [1:0] s, int idx, int pc);
    txn_t t;
    t.kind = kind; t.cyc = c; t.sel = s; t.idx = idx; t.pc = pc;
    exp_q.push_back(t);
  endtask

  task automatic expect_seq(logic [1:0] s, int start, int pc);
    push(K_START, start, s, 0, -1);
    for (int k = 1; k < NS; k++) push(K_STROBE, start + k * NC, s, k, -1);
    push(K_DONE, start + SEQ_LEN, s, -1, pc);
    push(K_IDLE, start + SEQ_LEN + GC, s, -1, -1);
  endtask

  task automatic wait_cycle(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(int n, logic [3:0] m);
    wait_cycle(n);
    {evt_end, evt_high, evt_score, evt_start} = m;
    @(posedge clk);
    #1;
    {evt_end, evt_high, evt_score, evt_start} = 4'b0000;
  endtask

  task automatic chk(string name, int got, int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, got, cyc);
    end
  endtask

  int play_cnt = 0;

  task automatic check_evt(int kind, int idx);
    txn_t t;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got cyc=%0d sel=%0d idx=%0d, required no event",
               kname(kind), cyc, sel, idx);
      return;
    end
    t = exp_q.pop_front();
    if (t.kind != kind || t.cyc != cyc || t.sel != sel ||
        (t.idx >= 0 && t.idx != idx) || (t.pc >= 0 && t.pc != play_cnt)) begin
      miscompares++;
      $display("FAIL %s: got %s cyc=%0d sel=%0d idx=%0d play_cycles=%0d, required %s cyc=%0d sel=%0d idx=%0d play_cycles=%0d",
               kname(t.kind), kname(kind), cyc, sel, idx, play_cnt,
               kname(t.kind), t.cyc, t.sel, t.idx, t.pc);
    end else begin
      $display("ok   %s cyc=%0d sel=%0d idx=%0d play_cycles=%0d", kname(kind), cyc, sel, idx, play_cnt);
    end
  endtask

  logic       prev_busy = 1'b0;
  logic [1:0] prev_sel = 2'b00;

  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      prev_sel  = sel;
      play_cnt  = 0;
    end else begin
      if (busy && (!prev_busy || sel != prev_sel)) begin
        play_cnt = 0;
        check_evt(K_START, int'(note_idx));
      end
      if (note_strobe) check_evt(K_STROBE, int'(note_idx));
      if (seq_done) check_evt(K_DONE, int'(note_idx));
      if (!busy && prev_busy) check_evt(K_IDLE, int'(note_idx));
      if (play) play_cnt++;
      prev_busy = busy;
      prev_sel  = sel;
    end
  end

  initial begin
    wait_cycle(2);
    chk("reset_outputs", int'({sel, note_idx, note_strobe, play, busy, seq_done}), 0);
    reset = 1'b0;

    // Single score event
    expect_seq(SEL_SCORE, 12, SEQ_LEN);
    pulse(10, 4'b0010);

    // Simultaneous start + end: end first, start after gap + idle
    expect_seq(SEL_END, 62, SEQ_LEN);
    expect_seq(SEL_START, 98, SEQ_LEN);
    pulse(60, 4'b1001);

    // Coalescing of repeated score events during playback
    expect_seq(SEL_SCORE, 142, SEQ_LEN);
    expect_seq(SEL_SCORE, 178, SEQ_LEN);
    pulse(140, 4'b0010);
    pulse(150, 4'b0010);
    pulse(160, 4'b0010);
    pulse(170, 4'b0010);

    // Muted high-score sequence keeps timing but never plays
    wait_cycle(220);
    mute = 1'b1;
    expect_seq(SEL_HIGH, 232, 0);
    pulse(230, 4'b0100);
    wait_cycle(270);
    mute = 1'b0;

    // Game over arrives during note 3 of a score sequence
`ifdef SOUND_PREEMPT_EN
    push(K_START, 282, SEL_SCORE, 0, -1);
    for (int k = 1; k <= 3; k++) push(K_STROBE, 282 + k * NC, SEL_SCORE, k, -1);
    expect_seq(SEL_END, 297, SEQ_LEN);
`else
    expect_seq(SEL_SCORE, 282, SEQ_LEN);
    expect_seq(SEL_END, 318, SEQ_LEN);
`endif
    pulse(280, 4'b0010);
    pulse(295, 4'b1000);

    // Reset mid-sequence with another event pending
    push(K_START, 372, SEL_START, 0, -1);
    push(K_STROBE, 376, SEL_START, 1, -1);
    pulse(370, 4'b0001);
    pulse(378, 4'b0010);
    wait_cycle(380);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", int'({sel, note_idx, note_strobe, play, busy, seq_done}), 0);
    wait_cycle(383);
    reset = 1'b0;
    wait_cycle(430);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_note_idx", int'(note_idx), 0);
    chk("unconsumed_expectations", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
